// File: rtl/game_pkg.sv
// Shared game definitions: command codes used by the key decoder and the game-state logic,
// plus the ASCII constants needed to recognise VT100 escape sequences.
package game_pkg;

    typedef enum logic [2:0] {
        CMD_UP       = 3'd0,
        CMD_DOWN     = 3'd1,
        CMD_LEFT     = 3'd2,
        CMD_RIGHT    = 3'd3,
        CMD_NEW_GAME = 3'd4,
        CMD_REDRAW   = 3'd5
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GOT_ESC = 2'd1,
        ST_GOT_CSI = 2'd2
    } key_state_t;

    localparam logic [7:0] ASC_ESC      = 8'h1B;
    localparam logic [7:0] ASC_LBRACKET = 8'h5B;
    localparam logic [7:0] ASC_SS3      = 8'h4F;

    // CSI parameter/intermediate bytes ('0'..'?') that may precede the final arrow letter
    function automatic logic is_csi_param(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h3F);
    endfunction

endpackage

// File: rtl/key_ascii_map.sv
// Single-keystroke lookup: maps one received byte to a game command.
// o_hit is low for bytes that have no single-byte meaning (including ESC).
module key_ascii_map
    import game_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic       o_hit,
    output cmd_t       o_cmd
);

    always_comb begin
        o_hit = 1'b1;
        o_cmd = CMD_UP;
        case (i_byte)
            8'h77, 8'h57:        o_cmd = CMD_UP;
            8'h73, 8'h53:        o_cmd = CMD_DOWN;
            8'h61, 8'h41:        o_cmd = CMD_LEFT;
            8'h64, 8'h44:        o_cmd = CMD_RIGHT;
            8'h6E, 8'h4E:        o_cmd = CMD_NEW_GAME;
            8'h72, 8'h52, 8'h0C: o_cmd = CMD_REDRAW;
            default:             o_hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_key_decoder.sv
// Turns UART receive bytes (WASD, VT100 arrows, new-game, redraw) into game commands
// held in a one-entry valid/ready output register with overrun detection.
//
// state       | meaning
// ST_IDLE     | no sequence in progress, bytes go through the single-byte map
// ST_GOT_ESC  | ESC seen, waiting for '[' or 'O' (or a plain key)
// ST_GOT_CSI  | ESC [ / ESC O seen, waiting for parameters or the final arrow letter
module uart_key_decoder
    import game_pkg::*;
#(
    parameter int ESC_TIMEOUT = 1000000,
    parameter int DROP_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic [2:0]            o_cmd,
    output logic                  o_cmd_valid,
    input  logic                  i_cmd_ready,
    output logic                  o_overrun,
    output logic [DROP_CNT_W-1:0] o_drop_cnt
);

    localparam int             TW       = (ESC_TIMEOUT > 1) ? $clog2(ESC_TIMEOUT) : 1;
    localparam logic [TW-1:0]  TMO_LAST = TW'(ESC_TIMEOUT - 1);

    key_state_t            r_state;
    key_state_t            w_state_nxt;
    logic [TW-1:0]         r_timer;
    logic                  w_expired;
    logic                  w_map_hit;
    cmd_t                  w_map_cmd;
    logic                  w_hit;
    cmd_t                  w_cmd;
    cmd_t                  r_cmd;
    logic                  r_cmd_valid;
    logic                  r_overrun;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    key_ascii_map u_map (
        .i_byte (i_rx_data),
        .o_hit  (w_map_hit),
        .o_cmd  (w_map_cmd)
    );

    assign w_expired = (r_state != ST_IDLE) && (r_timer == TMO_LAST);

    // A received byte always wins over the timeout in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_hit       = 1'b0;
        w_cmd       = w_map_cmd;
        case (r_state)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == ASC_ESC) w_state_nxt = ST_GOT_ESC;
                    else                      w_hit       = w_map_hit;
                end
            end
            ST_GOT_ESC: begin
                if (i_rx_valid) begin
                    if (i_rx_data == ASC_LBRACKET || i_rx_data == ASC_SS3) begin
                        w_state_nxt = ST_GOT_CSI;
                    end else if (i_rx_data != ASC_ESC) begin
                        w_state_nxt = ST_IDLE;
                        w_hit       = w_map_hit;
                    end
                end else if (w_expired) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GOT_CSI: begin
                if (i_rx_valid) begin
                    w_state_nxt = ST_IDLE;
                    case (i_rx_data)
                        8'h41: begin w_hit = 1'b1; w_cmd = CMD_UP;    end
                        8'h42: begin w_hit = 1'b1; w_cmd = CMD_DOWN;  end
                        8'h43: begin w_hit = 1'b1; w_cmd = CMD_RIGHT; end
                        8'h44: begin w_hit = 1'b1; w_cmd = CMD_LEFT;  end
                        default: begin
                            if (is_csi_param(i_rx_data)) w_state_nxt = ST_GOT_CSI;
                            else if (i_rx_data == ASC_ESC) w_state_nxt = ST_GOT_ESC;
                        end
                    endcase
                end else if (w_expired) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_cmd       <= CMD_UP;
            r_cmd_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (i_rx_valid || r_state == ST_IDLE || w_expired) r_timer <= '0;
            else                                              r_timer <= r_timer + 1'b1;

            r_overrun <= 1'b0;
            if (w_hit) begin
                if (!r_cmd_valid || i_cmd_ready) begin
                    r_cmd       <= w_cmd;
                    r_cmd_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                    if (r_drop_cnt != {DROP_CNT_W{1'b1}}) r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end else if (r_cmd_valid && i_cmd_ready) begin
                r_cmd_valid <= 1'b0;
            end
        end
    end

    assign o_cmd       = r_cmd;
    assign o_cmd_valid = r_cmd_valid;
    assign o_overrun   = r_overrun;
    assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_uart_key_decoder.sv
// Bench for uart_key_decoder: directed keystroke scenarios with literal expectations,
// then random byte traffic compared every cycle against a behavioural model.
module tb_uart_key_decoder;

    localparam int TMO = 16;
    localparam int DW  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          ready = 1'b0;
    logic [2:0]    cmd;
    logic          cmd_valid;
    logic          overrun;
    logic [DW-1:0] drop;

    always #5 clk = ~clk;

    uart_key_decoder #(.ESC_TIMEOUT(TMO), .DROP_CNT_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_cmd       (cmd),
        .o_cmd_valid (cmd_valid),
        .i_cmd_ready (ready),
        .o_overrun   (overrun),
        .o_drop_cnt  (drop)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = plain keys, 1 = after ESC, 2 = inside CSI/SS3.
    int m_mode = 0, m_cmd = 0, m_drop = 0, m_dec = -1;
    int cyc = 0, last_cyc = 0;
    bit m_valid = 0, m_ovr = 0, chk_en = 0;

    function automatic int plain_key(input logic [7:0] b);
        logic [7:0] l;
        l = (b >= 8'h41 && b <= 8'h5A) ? b + 8'h20 : b;
        case (l)
            8'h77: return 0;
            8'h73: return 1;
            8'h61: return 2;
            8'h64: return 3;
            8'h6E: return 4;
            8'h72, 8'h0C: return 5;
            default: return -1;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            m_mode = 0; m_cmd = 0; m_valid = 0; m_ovr = 0; m_drop = 0;
        end else begin
            m_dec = -1;
            if (rx_valid) begin
                last_cyc = cyc;
                if (m_mode == 0) begin
                    if (rx_data == 8'h1B) m_mode = 1;
                    else m_dec = plain_key(rx_data);
                end else if (m_mode == 1) begin
                    if (rx_data == 8'h5B || rx_data == 8'h4F) m_mode = 2;
                    else if (rx_data != 8'h1B) begin m_mode = 0; m_dec = plain_key(rx_data); end
                end else begin
                    m_mode = 0;
                    if (rx_data == 8'h41) m_dec = 0;
                    else if (rx_data == 8'h42) m_dec = 1;
                    else if (rx_data == 8'h43) m_dec = 3;
                    else if (rx_data == 8'h44) m_dec = 2;
                    else if (rx_data >= 8'h30 && rx_data <= 8'h3F) m_mode = 2;
                    else if (rx_data == 8'h1B) m_mode = 1;
                end
            end else if (m_mode != 0 && (cyc - last_cyc) >= TMO) begin
                m_mode = 0;
            end
            m_ovr = 0;
            if (m_dec >= 0) begin
                if (!m_valid || ready) begin m_cmd = m_dec; m_valid = 1; end
                else begin m_ovr = 1; if (m_drop < (1 << DW) - 1) m_drop++; end
            end else if (m_valid && ready) m_valid = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_cmd", int'(cmd), m_cmd);
            check("model_valid", int'(cmd_valid), int'(m_valid));
            check("model_overrun", int'(overrun), int'(m_ovr));
            check("model_drop", int'(drop), m_drop);
        end
    end

    logic [7:0] q[$];

    task automatic play();
        for (int i = 0; i < q.size(); i++) begin
            rx_data = q[i];
            rx_valid = 1'b1;
            @(posedge clk); #2;
        end
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    logic [7:0] pool [16] = '{8'h1B, 8'h5B, 8'h4F, 8'h41, 8'h42, 8'h43, 8'h44, 8'h31,
                              8'h3B, 8'h77, 8'h53, 8'h61, 8'h1B, 8'h6E, 8'h72, 8'h0C};

    initial begin
        int gap;
        int r;
        @(posedge clk); #2;
        chk_en = 1;
        idle(2);
        rst = 1'b1;
        check("reset_cmd", int'(cmd), 0);
        check("reset_valid", int'(cmd_valid), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_drop", int'(drop), 0);

        ready = 1'b1;
        q = '{8'h77}; play();
        check("w_cmd", int'(cmd), 0);
        check("w_valid", int'(cmd_valid), 1);
        idle(1);
        check("w_accepted", int'(cmd_valid), 0);
        q = '{8'h41}; play();
        check("A_left", int'(cmd), 2);
        q = '{8'h0C}; play();
        check("ctrl_l_redraw", int'(cmd), 5);
        check("ctrl_l_valid", int'(cmd_valid), 1);
        check("no_drop", int'(drop), 0);
        idle(2);

        q = '{8'h1B, 8'h5B, 8'h43}; play();
        check("csi_right", int'(cmd), 3);
        q = '{8'h1B, 8'h4F, 8'h42}; play();
        check("ss3_down", int'(cmd), 1);
        q = '{8'h1B, 8'h5B, 8'h31, 8'h3B, 8'h35, 8'h41}; play();
        check("csi_param_up", int'(cmd), 0);
        idle(1);
        q = '{8'h1B, 8'h5B, 8'h5A}; play();
        check("csi_bad_final", int'(cmd_valid), 0);
        q = '{8'h64}; play();
        check("after_bad_idle", int'(cmd), 3);
        idle(1);

        // After the escape has timed out, '[' is ignored and 'A' is an ordinary LEFT key.
        q = '{8'h1B}; play(); idle(20);
        q = '{8'h5B, 8'h41}; play();
        check("timeout_left", int'(cmd), 2);
        idle(1);
        q = '{8'h1B}; play(); idle(10);
        q = '{8'h5B, 8'h41}; play();
        check("gap10_up", int'(cmd), 0);
        idle(1);
        q = '{8'h1B}; play(); idle(TMO - 1);
        q = '{8'h5B, 8'h41}; play();
        check("expiry_cycle_up", int'(cmd), 0);
        idle(1);
        q = '{8'h1B}; play(); idle(TMO);
        q = '{8'h5B, 8'h41}; play();
        check("just_expired_left", int'(cmd), 2);
        idle(1);
        q = '{8'h1B, 8'h64}; play();
        check("esc_d_right", int'(cmd), 3);
        idle(2);

        ready = 1'b0;
        q = '{8'h77}; play();
        check("hold_cmd", int'(cmd), 0);
        q = '{8'h73}; play();
        check("ovr1_pulse", int'(overrun), 1);
        check("ovr1_drop", int'(drop), 1);
        q = '{8'h64}; play();
        check("ovr2_pulse", int'(overrun), 1);
        check("ovr2_drop", int'(drop), 2);
        check("ovr2_cmd_kept", int'(cmd), 0);
        idle(1);
        check("ovr_one_cycle", int'(overrun), 0);
        ready = 1'b1;
        idle(1);
        check("released", int'(cmd_valid), 0);

        q = '{8'h77, 8'h73}; play();
        check("b2b_cmd", int'(cmd), 1);
        check("b2b_valid", int'(cmd_valid), 1);
        idle(1);

        ready = 1'b0;
        q = '{8'h77, 8'h73, 8'h73, 8'h73, 8'h73, 8'h73, 8'h73, 8'h73, 8'h73}; play();
        check("drop_saturated", int'(drop), 7);
        ready = 1'b1;
        idle(2);

        q = '{8'h1B, 8'h5B}; play();
        rst = 1'b0; idle(1); rst = 1'b1;
        check("midseq_reset_valid", int'(cmd_valid), 0);
        check("midseq_reset_drop", int'(drop), 0);
        q = '{8'h41}; play();
        check("after_reset_left", int'(cmd), 2);

        gap = 0;
        for (int i = 0; i < 4000; i++) begin
            if (gap > 0) begin
                rx_valid = 1'b0;
                gap--;
            end else begin
                r = int'($urandom_range(0, 99));
                if (r < 3) gap = int'($urandom_range(5, 25));
                rx_valid = (r < 50);
                rx_data = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 15)];
            end
            ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 499) != 0);
            @(posedge clk); #2;
        end
        rx_valid = 1'b0;
        rst = 1'b1;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
